// File: rtl/bp_nonsynth_perf_mc.sv
// Per-core performance monitor: warmup, measured cycle/instruction counts, pass/stat prints.
// Define BP_NONSYNTH_PERF_WATCHDOG_EN to enable the no-commit watchdog that drives fail_o.
module bp_nonsynth_perf_mc
  #(parameter int num_core_p       = 1
   ,parameter int commit_width_p   = 1
   ,parameter int cnt_width_p      = 64
   ,parameter bit finish_on_done_p = 1'b1
   ,localparam int commit_cnt_w_lp = $clog2(commit_width_p+1)
   )
  (input  logic                                    clk_i
  ,input  logic                                    reset_i
  ,input  logic [31:0]                             warmup_instr_i
  ,input  logic [31:0]                             max_instr_i
  ,input  logic [31:0]                             timeout_cycles_i
  ,input  logic [num_core_p*commit_cnt_w_lp-1:0]   commit_cnt_i
  ,input  logic [num_core_p-1:0]                   is_debug_mode_i
  ,output logic [num_core_p*2-1:0]                 state_o
  ,output logic [num_core_p*cnt_width_p-1:0]       clk_cnt_o
  ,output logic [num_core_p*cnt_width_p-1:0]       instr_cnt_o
  ,output logic                                    all_done_o
  ,output logic                                    fail_o
  );

  localparam int cmp_w_lp = (cnt_width_p > 32) ? cnt_width_p : 32;

  typedef enum logic [1:0] {e_warmup = 2'd0, e_measure = 2'd1, e_done = 2'd2} state_e;

  logic [num_core_p-1:0] core_done;

  for (genvar gi = 0; gi < num_core_p; gi++) begin : g_core
    state_e                     state_q, state_d;
    logic [31:0]                warm_q, warm_d;
    logic [cnt_width_p-1:0]     clk_q, clk_d, instr_q, instr_d;
    logic [commit_cnt_w_lp-1:0] commit, commit_eff;
    logic [32:0]                warm_sum;
    logic [cnt_width_p:0]       clk_sum, instr_sum;
    logic [cnt_width_p-1:0]     clk_sat, instr_sat;
    logic                       done;

    assign commit     = commit_cnt_i[gi*commit_cnt_w_lp +: commit_cnt_w_lp];
    assign commit_eff = is_debug_mode_i[gi] ? '0 : commit;
    assign warm_sum   = {1'b0, warm_q} + 33'(commit_eff);
    assign clk_sum    = {1'b0, clk_q} + (cnt_width_p+1)'(1);
    assign instr_sum  = {1'b0, instr_q} + (cnt_width_p+1)'(commit_eff);
    // Saturate instead of wrapping so long runs never report tiny counts
    assign clk_sat    = clk_sum[cnt_width_p]   ? '1 : clk_sum[cnt_width_p-1:0];
    assign instr_sat  = instr_sum[cnt_width_p] ? '1 : instr_sum[cnt_width_p-1:0];

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        state_q <= e_warmup;
        warm_q  <= '0;
        clk_q   <= '0;
        instr_q <= '0;
      end else begin
        state_q <= state_d;
        warm_q  <= warm_d;
        clk_q   <= clk_d;
        instr_q <= instr_d;
      end
    end

    always_comb begin
      state_d = state_q;
      warm_d  = warm_q;
      clk_d   = clk_q;
      instr_d = instr_q;
      unique case (state_q)
        e_warmup: begin
          // Commits of the transition cycle stay in the warmup count only
          warm_d = warm_sum[31:0];
          if (warm_sum >= {1'b0, warmup_instr_i})
            state_d = e_measure;
        end
        e_measure: begin
          if (!is_debug_mode_i[gi]) begin
            clk_d   = clk_sat;
            instr_d = instr_sat;
            if ((max_instr_i != '0) && (cmp_w_lp'(instr_sat) >= cmp_w_lp'(max_instr_i)))
              state_d = e_done;
          end
        end
        default: ;
      endcase
    end

    always_comb begin
      done = (state_q == e_done);
    end

    assign core_done[gi]                           = done;
    assign state_o[gi*2 +: 2]                      = state_q;
    assign clk_cnt_o[gi*cnt_width_p +: cnt_width_p]   = clk_q;
    assign instr_cnt_o[gi*cnt_width_p +: cnt_width_p] = instr_q;
  end

  logic all_done_q, all_done_d;
  assign all_done_d = all_done_q | (&core_done);

  always_ff @(posedge clk_i) begin
    if (reset_i) all_done_q <= 1'b0;
    else         all_done_q <= all_done_d;
  end
  assign all_done_o = all_done_q;

`ifdef BP_NONSYNTH_PERF_WATCHDOG_EN
  logic [31:0] wd_q, wd_d;
  logic        fail_q, fail_d;

  always_comb begin
    wd_d = wd_q;
    if (|commit_cnt_i)     wd_d = '0;
    else if (wd_q != '1)   wd_d = wd_q + 32'd1;
    fail_d = fail_q | ((timeout_cycles_i != '0) && (wd_d >= timeout_cycles_i) && !all_done_q);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wd_q   <= '0;
      fail_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      fail_q <= fail_d;
    end
  end
  assign fail_o = fail_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_cycles_i;
  assign fail_o = 1'b0;
`endif

`ifndef SYNTHESIS
  logic pass_seen_q, fail_seen_q;

  always_ff @(negedge clk_i) begin
    if (reset_i) begin
      pass_seen_q <= 1'b0;
      fail_seen_q <= 1'b0;
    end else begin
      if (all_done_q && !pass_seen_q) begin
        pass_seen_q <= 1'b1;
        $display("[BSG-PASS] max_instr=%0d", max_instr_i);
        if (finish_on_done_p) $finish;
      end
      if (fail_o && !fail_seen_q) begin
        fail_seen_q <= 1'b1;
        $display("[BSG-FAIL]: watchdog");
        if (finish_on_done_p) $finish;
      end
    end
  end

  final begin
    $display("[BSG-STAT]");
    for (int n = 0; n < num_core_p; n++) begin
      logic [cnt_width_p+9:0] c_l, i_l, mipc_l;
      c_l    = (cnt_width_p+10)'(clk_cnt_o[n*cnt_width_p +: cnt_width_p]);
      i_l    = (cnt_width_p+10)'(instr_cnt_o[n*cnt_width_p +: cnt_width_p]);
      mipc_l = (c_l == '0) ? '0 : (i_l * (cnt_width_p+10)'(1000)) / c_l;
      $display("core%0d clk=%0d instr=%0d mIPC=%0d", n, c_l, i_l, mipc_l);
    end
  end
`endif

endmodule

// File: tb/tb_bp_nonsynth_perf_mc.sv
// Directed bench: table-driven vectors for a 2-wide core plus multi-cycle sequences
// for warmup/done timing, two-core completion, saturation and the watchdog.
module tb_bp_nonsynth_perf_mc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

`ifdef BP_NONSYNTH_PERF_WATCHDOG_EN
  localparam bit wd_en = 1'b1;
`else
  localparam bit wd_en = 1'b0;
`endif

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A: single core, warmup 10, max 20
  logic        rst_a = 1'b1;
  logic [0:0]  cmt_a = '0, dbg_a = '0;
  logic [1:0]  st_a;
  logic [63:0] clk_a, ins_a;
  logic        ad_a, fail_a;
  bp_nonsynth_perf_mc #(.num_core_p(1), .commit_width_p(1), .cnt_width_p(64), .finish_on_done_p(1'b0)) u_a (
    .clk_i(clk), .reset_i(rst_a), .warmup_instr_i(32'd10), .max_instr_i(32'd20), .timeout_cycles_i(32'd0),
    .commit_cnt_i(cmt_a), .is_debug_mode_i(dbg_a), .state_o(st_a), .clk_cnt_o(clk_a), .instr_cnt_o(ins_a),
    .all_done_o(ad_a), .fail_o(fail_a));

  // B: 2-wide commit, warmup 3, max 5
  logic        rst_b = 1'b1;
  logic [1:0]  cmt_b = '0;
  logic [0:0]  dbg_b = '0;
  logic [1:0]  st_b;
  logic [63:0] clk_b, ins_b;
  logic        ad_b, fail_b;
  bp_nonsynth_perf_mc #(.num_core_p(1), .commit_width_p(2), .cnt_width_p(64), .finish_on_done_p(1'b0)) u_b (
    .clk_i(clk), .reset_i(rst_b), .warmup_instr_i(32'd3), .max_instr_i(32'd5), .timeout_cycles_i(32'd0),
    .commit_cnt_i(cmt_b), .is_debug_mode_i(dbg_b), .state_o(st_b), .clk_cnt_o(clk_b), .instr_cnt_o(ins_b),
    .all_done_o(ad_b), .fail_o(fail_b));

  // C: two cores, warmup 0, max 8
  logic         rst_c = 1'b1;
  logic [1:0]   cmt_c = '0, dbg_c = '0;
  logic [3:0]   st_c;
  logic [127:0] clk_c, ins_c;
  logic         ad_c, fail_c;
  bp_nonsynth_perf_mc #(.num_core_p(2), .commit_width_p(1), .cnt_width_p(64), .finish_on_done_p(1'b0)) u_c (
    .clk_i(clk), .reset_i(rst_c), .warmup_instr_i(32'd0), .max_instr_i(32'd8), .timeout_cycles_i(32'd0),
    .commit_cnt_i(cmt_c), .is_debug_mode_i(dbg_c), .state_o(st_c), .clk_cnt_o(clk_c), .instr_cnt_o(ins_c),
    .all_done_o(ad_c), .fail_o(fail_c));

  // D: 4-bit counters, unlimited, watchdog timeout 50
  logic        rst_d = 1'b1;
  logic [0:0]  cmt_d = '0, dbg_d = '0;
  logic [1:0]  st_d;
  logic [3:0]  clk_d, ins_d;
  logic        ad_d, fail_d;
  bp_nonsynth_perf_mc #(.num_core_p(1), .commit_width_p(1), .cnt_width_p(4), .finish_on_done_p(1'b0)) u_d (
    .clk_i(clk), .reset_i(rst_d), .warmup_instr_i(32'd0), .max_instr_i(32'd0), .timeout_cycles_i(32'd50),
    .commit_cnt_i(cmt_d), .is_debug_mode_i(dbg_d), .state_o(st_d), .clk_cnt_o(clk_d), .instr_cnt_o(ins_d),
    .all_done_o(ad_d), .fail_o(fail_d));

  typedef struct {
    logic            rst;
    logic [1:0]      cmt;
    logic            dbg;
    logic [1:0]      st;
    longint unsigned clk_cnt;
    longint unsigned ins_cnt;
    logic            ad;
  } vec_t;

  vec_t vt[16];

  initial begin
    // Expected values are the outputs just after the edge that consumes the inputs.
    vt[0]  = '{1'b1, 2'd0, 1'b0, 2'd0, 0, 0, 1'b0};
    vt[1]  = '{1'b0, 2'd2, 1'b0, 2'd0, 0, 0, 1'b0};
    vt[2]  = '{1'b0, 2'd2, 1'b0, 2'd1, 0, 0, 1'b0};
    vt[3]  = '{1'b0, 2'd2, 1'b0, 2'd1, 1, 2, 1'b0};
    vt[4]  = '{1'b0, 2'd1, 1'b1, 2'd1, 1, 2, 1'b0};
    vt[5]  = '{1'b0, 2'd2, 1'b0, 2'd1, 2, 4, 1'b0};
    vt[6]  = '{1'b0, 2'd2, 1'b0, 2'd2, 3, 6, 1'b0};
    vt[7]  = '{1'b0, 2'd2, 1'b0, 2'd2, 3, 6, 1'b1};
    vt[8]  = '{1'b0, 2'd0, 1'b0, 2'd2, 3, 6, 1'b1};
    vt[9]  = '{1'b1, 2'd2, 1'b0, 2'd0, 0, 0, 1'b0};
    vt[10] = '{1'b0, 2'd1, 1'b0, 2'd0, 0, 0, 1'b0};
    vt[11] = '{1'b0, 2'd1, 1'b1, 2'd0, 0, 0, 1'b0};
    vt[12] = '{1'b0, 2'd1, 1'b0, 2'd0, 0, 0, 1'b0};
    vt[13] = '{1'b0, 2'd1, 1'b0, 2'd1, 0, 0, 1'b0};
    vt[14] = '{1'b0, 2'd0, 1'b0, 2'd1, 1, 0, 1'b0};
    vt[15] = '{1'b0, 2'd2, 1'b0, 2'd1, 2, 2, 1'b0};

    for (int r = 0; r < 16; r++) begin
      rst_b = vt[r].rst;
      cmt_b = vt[r].cmt;
      dbg_b = vt[r].dbg;
      step();
      $display("B row %0d st=%0d clk=%0d instr=%0d all_done=%0b", r, st_b, clk_b, ins_b, ad_b);
      check($sformatf("b%0d_state", r), st_b, vt[r].st);
      check($sformatf("b%0d_clk", r), clk_b, vt[r].clk_cnt);
      check($sformatf("b%0d_instr", r), ins_b, vt[r].ins_cnt);
      check($sformatf("b%0d_all_done", r), ad_b, vt[r].ad);
    end

    // A: reset state, then one commit every cycle
    rst_a = 1'b1;
    step();
    check("a_rst_state", st_a, 0);
    check("a_rst_clk", clk_a, 0);
    check("a_rst_instr", ins_a, 0);
    check("a_rst_all_done", ad_a, 0);
    check("a_rst_fail", fail_a, 0);
    rst_a = 1'b0;
    cmt_a = 1'b1;
    for (int cyc = 0; cyc < 32; cyc++) begin
      step();
      $display("A cyc %0d st=%0d clk=%0d instr=%0d all_done=%0b", cyc, st_a, clk_a, ins_a, ad_a);
      if (cyc == 8) check("a_warm8", st_a, 0);
      if (cyc == 9) begin
        check("a_meas9_state", st_a, 1);
        check("a_meas9_instr", ins_a, 0);
      end
      if (cyc == 28) begin
        check("a_c28_state", st_a, 1);
        check("a_c28_instr", ins_a, 19);
      end
      if (cyc == 29) begin
        check("a_done_state", st_a, 2);
        check("a_done_clk", clk_a, 20);
        check("a_done_instr", ins_a, 20);
        check("a_done_all_done_early", ad_a, 0);
      end
      if (cyc == 30) begin
        check("a_all_done", ad_a, 1);
        check("a_hold_instr", ins_a, 20);
      end
    end
    check("a_fail_off", fail_a, 0);

    // A: debug freeze for five measured cycles
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      dbg_a = (cyc >= 13 && cyc < 18) ? 1'b1 : 1'b0;
      step();
      $display("A dbg cyc %0d dbg=%0b clk=%0d instr=%0d", cyc, dbg_a, clk_a, ins_a);
      if (cyc == 12) check("a_pre_dbg_clk", clk_a, 3);
      if (cyc == 17) begin
        check("a_dbg_clk_frozen", clk_a, 3);
        check("a_dbg_instr_frozen", ins_a, 3);
      end
      if (cyc == 19) begin
        check("a_resume_clk", clk_a, 5);
        check("a_resume_instr", ins_a, 5);
      end
    end
    dbg_a = 1'b0;
    cmt_a = 1'b0;

    // C: core0 every cycle, core1 every other cycle
    rst_c = 1'b1;
    step();
    rst_c = 1'b0;
    for (int cyc = 0; cyc < 18; cyc++) begin
      cmt_c = {(cyc % 2 == 1) ? 1'b1 : 1'b0, 1'b1};
      step();
      $display("C cyc %0d st=%0h clk0=%0d clk1=%0d instr1=%0d all_done=%0b",
               cyc, st_c, clk_c[63:0], clk_c[127:64], ins_c[127:64], ad_c);
      if (cyc == 0) check("c_both_measure", st_c, 4'b0101);
      if (cyc == 8) begin
        check("c_core0_done", st_c[1:0], 2);
        check("c_core0_clk", clk_c[63:0], 8);
        check("c_core0_instr", ins_c[63:0], 8);
      end
      if (cyc == 14) begin
        check("c_core1_state14", st_c[3:2], 1);
        check("c_core1_instr14", ins_c[127:64], 7);
        check("c_core0_frozen", clk_c[63:0], 8);
        check("c_all_done_wait", ad_c, 0);
      end
      if (cyc == 15) begin
        check("c_core1_done", st_c[3:2], 2);
        check("c_core1_clk", clk_c[127:64], 15);
        check("c_core1_instr", ins_c[127:64], 8);
        check("c_all_done_lag", ad_c, 0);
      end
      if (cyc == 16) check("c_all_done", ad_c, 1);
    end
    cmt_c = '0;

    // D: saturation, then commits stop for the watchdog
    rst_d = 1'b1;
    step();
    rst_d = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      cmt_d = (cyc < 25) ? 1'b1 : 1'b0;
      step();
      $display("D cyc %0d st=%0d clk=%0d instr=%0d fail=%0b", cyc, st_d, clk_d, ins_d, fail_d);
      if (cyc == 14) check("d_clk14", clk_d, 14);
      if (cyc == 24) begin
        check("d_sat_clk", clk_d, 15);
        check("d_sat_instr", ins_d, 15);
        check("d_sat_state", st_d, 1);
      end
      if (cyc == 73) check("d_fail_before", fail_d, 0);
      if (cyc == 74) check("d_fail_at_timeout", fail_d, wd_en);
      if (cyc == 79) check("d_fail_sticky", fail_d, wd_en);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bp_nonsynth_perf_mc.md
BP_NONSYNTH_PERF_MC -- requirements
Module: bp_nonsynth_perf_mc

Interface
REQ-001 Parameter num_core_p, default 1, number of monitored cores (channels).
REQ-002 Parameter commit_width_p, default 1, maximum instructions a core commits per cycle.
REQ-003 Parameter cnt_width_p, default 64, width of the clock and instruction counters.
REQ-004 clk_i  input  1  single clock; all state updates on posedge.
REQ-005 reset_i  input  1  synchronous, active-high reset.
REQ-006 warmup_instr_i  input  32  per-core instructions committed before measurement starts.
REQ-007 max_instr_i  input  32  per-core measured instructions to reach DONE; 0 means unlimited.
REQ-008 timeout_cycles_i  input  32  watchdog limit in cycles; 0 disables the watchdog.
REQ-009 commit_cnt_i  input  num_core_p*clog2(commit_width_p+1)  per-core commits this cycle; core n in slice n.
REQ-010 is_debug_mode_i  input  num_core_p  per-core debug-mode flag.
REQ-011 state_o  output  num_core_p*2  per-core FSM state: 0 WARMUP, 1 MEASURE, 2 DONE.
REQ-012 clk_cnt_o  output  num_core_p*cnt_width_p  per-core measured cycles.
REQ-013 instr_cnt_o  output  num_core_p*cnt_width_p  per-core measured instructions.
REQ-014 all_done_o  output  1  sticky; all cores reached DONE.
REQ-015 fail_o  output  1  sticky watchdog failure.

Function
REQ-016 Each core SHALL run an independent FSM WARMUP -> MEASURE -> DONE, with no other transitions except reset.
REQ-017 In WARMUP, a 32-bit warmup counter SHALL add commit_cnt_i each cycle that is_debug_mode_i is low; when counter+commit >= warmup_instr_i, state SHALL be MEASURE on the next edge.
REQ-018 With warmup_instr_i=0, a core SHALL be in MEASURE on the first cycle after reset deassertion.
REQ-019 Commits in the WARMUP->MEASURE transition cycle, including any overshoot, SHALL NOT be counted as measured instructions.
REQ-020 In MEASURE with debug low, clk_cnt SHALL add 1 and instr_cnt SHALL add commit_cnt_i each cycle.
REQ-021 In MEASURE with debug high, both counters SHALL hold their values (freeze, not clear).
REQ-022 When max_instr_i>0 and the updated instr_cnt >= max_instr_i, state SHALL become DONE on the same edge as that update; overshoot commits SHALL be counted.
REQ-023 In DONE, counters SHALL hold; commits are ignored.
REQ-024 Counters SHALL saturate at 2^cnt_width_p-1 and never wrap.
REQ-025 all_done_o SHALL assert one cycle after every core is in DONE and SHALL stay high until reset.
REQ-026 On a negedge with all_done_o high, the block SHALL print "[BSG-PASS]" with max_instr_i and call $finish.
REQ-027 The final block SHALL print "[BSG-STAT]" and per-core clk, instr, and mIPC = instr*1000/clk; when clk=0, mIPC SHALL print 0.

Reset
REQ-028 On reset_i: all states WARMUP, warmup/clk/instr/watchdog counters 0, all_done_o=0, fail_o=0.
REQ-029 Reset asserted mid-measurement SHALL discard all counts; no PASS/FAIL print occurs that cycle.

Configuration
REQ-030 Macro BP_NONSYNTH_PERF_WATCHDOG_EN SHALL gate the watchdog.
REQ-031 With the macro defined: a cycle counter SHALL clear on any nonzero commit_cnt_i and otherwise increment. When it reaches timeout_cycles_i (nonzero) and all_done_o is low, fail_o SHALL set (sticky). On the next negedge, the block SHALL print "[BSG-FAIL]: watchdog" and call $finish.
REQ-032 Without the macro: no watchdog logic; fail_o tied 0; timeout_cycles_i ignored.

Verification
REQ-033 num_core_p=1, warmup=10, max=20, one commit every cycle -> MEASURE at cycle 10; DONE with instr_cnt=20, clk_cnt=20; all_done_o one cycle later; PASS print.
REQ-034 commit_width_p=2, warmup=3, 2 commits/cycle -> transition-cycle overshoot discarded; with max=5, final instr_cnt=6.
REQ-035 num_core_p=2, max=8, core1 commits half as often -> all_done_o only after core1 DONE; core0 counters frozen meanwhile.
REQ-036 Debug high for 5 cycles in MEASURE -> clk_cnt and instr_cnt unchanged over those cycles, then resume from held values.
REQ-037 cnt_width_p=4, max=0, continuous commits -> counters saturate at 15; state stays MEASURE.
REQ-038 BP_NONSYNTH_PERF_WATCHDOG_EN defined, timeout=50, commits stop -> fail_o high 50 cycles after last commit; FAIL print; undefined -> fail_o stays 0.
